ald_valve_driver: RTL and testbench



---
 rtl/ald_pkg.sv | 26 ++
 rtl/ald_chan_timer.sv | 67 ++++++
 rtl/ald_valve_driver.sv | 90 +++++++++
 tb/tb_ald_valve_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ald_pkg.sv
// Shared constants and types for the ALD valve output stage.
// Tick defaults match the ladder's timer presets (1 kHz ticks).
package ald_pkg;

    localparam int CH_SV1  = 0;
    localparam int CH_SV4  = 1;
    localparam int CH_VV1  = 2;
    localparam int CH_VV2  = 3;
    localparam int CH_HEAT = 4;
    localparam int CH_MFCW = 5;

    localparam int DEF_N_CH    = 6;
    localparam int DEF_MIN_ON  = 20;
    localparam int DEF_MIN_OFF = 20;
    localparam int DEF_DEAD    = 50;
    localparam int DEF_WDOG    = 100;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        OFF_READY,
        ON_HOLD,
        ON_READY,
        OFF_HOLD
    } chan_state_t;

endpackage

// File: rtl/ald_chan_timer.sv
// One output channel: min-on/min-off hold FSM with its tick counter.
// force_off overrides everything and parks the channel in OFF_HOLD.
module ald_chan_timer
    import ald_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int MIN_ON_TICKS  = DEF_MIN_ON,
    parameter int MIN_OFF_TICKS = DEF_MIN_OFF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic req,
    input  logic permit,
    input  logic force_off,
    output logic drv,
    output logic idle,
    output logic off_evt
);

    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(MIN_ON_TICKS);
    localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(MIN_OFF_TICKS);

    chan_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OFF_READY;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Loads below overwrite the decrement, so a coincident tick is dropped.
    always_comb begin
        state_d = state;
        cnt_d   = (tick && cnt != '0) ? cnt - CNT_W'(1) : cnt;
        if (force_off) begin
            state_d = OFF_HOLD;
            cnt_d   = OFF_LD;
        end else begin
            unique case (state)
                OFF_READY: if (req && permit) begin
                    state_d = ON_HOLD;
                    cnt_d   = ON_LD;
                end
                ON_HOLD:   if (cnt == '0) state_d = ON_READY;
                ON_READY:  if (!req) begin
                    state_d = OFF_HOLD;
                    cnt_d   = OFF_LD;
                end
                OFF_HOLD:  if (cnt == '0) state_d = OFF_READY;
                default:   state_d = OFF_READY;
            endcase
        end
    end

    always_comb begin
        drv     = (state == ON_HOLD) || (state == ON_READY);
        idle    = (state == OFF_READY);
        off_evt = drv && (state_d == OFF_HOLD);
    end

endmodule

// File: rtl/ald_valve_driver.sv
// Valve output stage: captures the ladder coil image, applies per-channel
// hold timers, the SV1/SV4 break-before-make interlock, estop and watchdog.
module ald_valve_driver
    import ald_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int MIN_ON_TICKS  = DEF_MIN_ON,
    parameter int MIN_OFF_TICKS = DEF_MIN_OFF,
    parameter int DEAD_TICKS    = DEF_DEAD,
    parameter int WDOG_TICKS    = DEF_WDOG,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            scan_valid,
    input  logic [N_CH-1:0] cmd,
    input  logic            estop,
    input  logic            fault_clr,
    output logic [N_CH-1:0] drv,
    output logic [N_CH-1:0] pending,
    output logic            conflict,
    output logic            wdog_fault
);

    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_TICKS);
    localparam logic [CNT_W-1:0] WDOG_MX = CNT_W'(WDOG_TICKS);
    localparam logic [CNT_W-1:0] WDOG_M1 = CNT_W'(WDOG_TICKS - 1);
    localparam logic [N_CH-1:0]  IL_MASK = N_CH'(3);

    logic [N_CH-1:0]  cmd_q, cmd_d;
    logic [N_CH-1:0]  idle, off_evt, permit;
    logic [CNT_W-1:0] dead, wdog_cnt;
    logic             wdog_trip, kill, both_req;

    // The channels act on the image being committed this cycle, giving
    // a single clk from scan_valid to drv.
    always_comb begin
        wdog_trip = !scan_valid && tick && (wdog_cnt == WDOG_M1);
        kill      = estop || wdog_trip;
        cmd_d     = cmd_q;
        if (scan_valid && !wdog_fault) cmd_d = cmd;
        if (kill) cmd_d = '0;
        both_req  = ((idle & cmd_d & IL_MASK) == IL_MASK);
        permit    = '1;
        permit[CH_SV1] = !drv[CH_SV4] && dead == '0 && !both_req;
        permit[CH_SV4] = !drv[CH_SV1] && dead == '0 && !both_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q      <= '0;
            dead       <= '0;
            wdog_cnt   <= '0;
            wdog_fault <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            cmd_q <= cmd_d;
            if (kill || |(off_evt & IL_MASK)) dead <= DEAD_LD;
            else if (tick && dead != '0)      dead <= dead - CNT_W'(1);
            if (scan_valid || fault_clr)        wdog_cnt <= '0;
            else if (tick && wdog_cnt != WDOG_MX) wdog_cnt <= wdog_cnt + CNT_W'(1);
            if (wdog_trip)      wdog_fault <= 1'b1;
            else if (fault_clr) wdog_fault <= 1'b0;
            if (both_req)       conflict <= 1'b1;
            else if (fault_clr) conflict <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ald_chan_timer #(
            .CNT_W        (CNT_W),
            .MIN_ON_TICKS (MIN_ON_TICKS),
            .MIN_OFF_TICKS(MIN_OFF_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .req      (cmd_d[i]),
            .permit   (permit[i]),
            .force_off(kill),
            .drv      (drv[i]),
            .idle     (idle[i]),
            .off_evt  (off_evt[i])
        );
    end

    assign pending = cmd_q & ~drv;

endmodule

// File: tb/tb_ald_valve_driver.sv
// Directed bench for ald_valve_driver: vector table plus interlock,
// estop, watchdog and async-reset sequences.
module tb_ald_valve_driver;
    import ald_pkg::*;

    logic       clk = 1'b0;
    logic       rst, tick, scan_valid, estop, fault_clr;
    logic [5:0] cmd, drv, pending;
    logic       conflict, wdog_fault;

    int         checks = 0;
    int         errors = 0;
    int         tick_n = 0;
    logic [5:0] cmd_reg = '0;
    bit         auto_scan = 1'b1;

    typedef struct {
        logic [5:0] cmd;
        int         ticks;
        logic [5:0] drv;
        logic [5:0] pend;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    ald_valve_driver dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .scan_valid(scan_valid),
        .cmd       (cmd),
        .estop     (estop),
        .fault_clr (fault_clr),
        .drv       (drv),
        .pending   (pending),
        .conflict  (conflict),
        .wdog_fault(wdog_fault)
    );

    task automatic chk(input string name, input logic [5:0] act,
                       input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Inputs change at #1 after posedge; outputs are sampled there too.
    task automatic cyc(input logic t, input logic s);
        tick       = t;
        scan_valid = s;
        cmd        = cmd_reg;
        @(posedge clk);
        #1;
        tick       = 1'b0;
        scan_valid = 1'b0;
        fault_clr  = 1'b0;
    endtask

    task automatic do_tick();
        cyc(1'b1, 1'b0);
        tick_n++;
        cyc(1'b0, auto_scan && (tick_n % 10 == 0));
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    task automatic scan(input logic [5:0] c);
        cmd_reg = c;
        cyc(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        estop = 1'b0;
        fault_clr = 1'b0;
        cmd_reg = '0;
        auto_scan = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        tick = 1'b0;
        scan_valid = 1'b0;
        estop = 1'b0;
        fault_clr = 1'b0;
        cmd = '0;

        tbl[0] = '{6'b000100,  0, 6'b000100, 6'b000000};
        tbl[1] = '{6'b000100,  5, 6'b000100, 6'b000000};
        tbl[2] = '{6'b000000, 14, 6'b000100, 6'b000000};
        tbl[3] = '{6'b000000,  1, 6'b000000, 6'b000000};
        tbl[4] = '{6'b101000,  0, 6'b101000, 6'b000000};
        tbl[5] = '{6'b101000, 20, 6'b101000, 6'b000000};
        tbl[6] = '{6'b000000,  0, 6'b000000, 6'b000000};
        tbl[7] = '{6'b001000,  0, 6'b000000, 6'b001000};
        tbl[8] = '{6'b001000, 19, 6'b000000, 6'b001000};
        tbl[9] = '{6'b001000,  1, 6'b001000, 6'b000000};

        do_reset();
        chk("rst_drv", drv, 6'b0);
        chk("rst_pend", pending, 6'b0);
        chk("rst_conf", {5'b0, conflict}, 6'b0);
        chk("rst_wdog", {5'b0, wdog_fault}, 6'b0);

        for (int i = 0; i < 10; i++) begin
            scan(tbl[i].cmd);
            run(tbl[i].ticks);
            chk($sformatf("vec%0d_drv", i), drv, tbl[i].drv);
            chk($sformatf("vec%0d_pend", i), pending, tbl[i].pend);
        end

        // SV1 -> SV4 changeover with dead time
        do_reset();
        scan(6'b000001);
        chk("il_sv1_on", drv, 6'b000001);
        run(20);
        scan(6'b000010);
        chk("il_sv1_off", drv, 6'b000000);
        chk("il_pend", pending, 6'b000010);
        run(49);
        chk("il_dead49", drv, 6'b000000);
        chk("il_pend49", pending, 6'b000010);
        run(1);
        chk("il_sv4_on", drv, 6'b000010);

        // Simultaneous SV1+SV4 request; set beats coincident clear
        do_reset();
        fault_clr = 1'b1;
        scan(6'b000011);
        chk("cf_drv", drv, 6'b000000);
        chk("cf_flag", {5'b0, conflict}, 6'b000001);
        chk("cf_pend", pending, 6'b000011);
        run(2);
        chk("cf_hold", drv, 6'b000000);
        scan(6'b000001);
        chk("cf_sv1", drv, 6'b000001);
        chk("cf_sticky", {5'b0, conflict}, 6'b000001);
        fault_clr = 1'b1;
        cyc(1'b0, 1'b0);
        chk("cf_clr", {5'b0, conflict}, 6'b000000);

        // Emergency stop and recovery
        do_reset();
        scan(6'b111101);
        chk("es_on", drv, 6'b111101);
        run(25);
        estop = 1'b1;
        cyc(1'b0, 1'b0);
        chk("es_drv", drv, 6'b000000);
        chk("es_pend", pending, 6'b000000);
        run(3);
        estop = 1'b0;
        scan(6'b111101);
        run(19);
        chk("es_off19", drv, 6'b000000);
        chk("es_pend19", pending, 6'b111101);
        run(1);
        chk("es_back", drv, 6'b111100);
        run(29);
        chk("es_dead", drv, 6'b111100);
        run(1);
        chk("es_sv1", drv, 6'b111101);

        // Scan watchdog
        do_reset();
        scan(6'b000100);
        auto_scan = 1'b0;
        run(99);
        chk("wd_99", {5'b0, wdog_fault}, 6'b000000);
        chk("wd_99drv", drv, 6'b000100);
        run(1);
        chk("wd_trip", {5'b0, wdog_fault}, 6'b000001);
        chk("wd_drv", drv, 6'b000000);
        scan(6'b000100);
        chk("wd_ign", pending, 6'b000000);
        chk("wd_stay", {5'b0, wdog_fault}, 6'b000001);
        fault_clr = 1'b1;
        cyc(1'b0, 1'b0);
        chk("wd_clr", {5'b0, wdog_fault}, 6'b000000);
        scan(6'b000100);
        chk("wd_acc", pending, 6'b000100);
        auto_scan = 1'b1;
        run(20);
        chk("wd_back", drv, 6'b000100);

        // Asynchronous reset during ON_HOLD
        do_reset();
        scan(6'b000011);
        scan(6'b000100);
        run(3);
        chk("ar_pre_drv", drv, 6'b000100);
        chk("ar_pre_cf", {5'b0, conflict}, 6'b000001);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_drv", drv, 6'b000000);
        chk("ar_pend", pending, 6'b000000);
        chk("ar_cf", {5'b0, conflict}, 6'b000000);
        chk("ar_wd", {5'b0, wdog_fault}, 6'b000000);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
